// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter in front of a shared 4-bit FIFO.
// One owner at a time writes up to BURST_MAX beats, then yields.
module fifo_write_arbiter #(
    parameter int NREQ      = 4,
    parameter int BURST_MAX = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    input  logic              fifo_full,
    output logic              fifo_write_en,
    output logic [3:0]        fifo_data_in,
    output logic              grant_valid,
    output logic [1:0]        grant_id
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    state_e     state_q;
    state_e     state_d;
    logic [1:0] grant_id_q;
    logic [1:0] grant_id_d;
    logic [2:0] beat_cnt_q;
    logic [2:0] beat_cnt_d;
    logic [1:0] rr_ptr_q;
    logic [1:0] rr_ptr_d;

    logic       pick_found;
    logic [1:0] pick_idx;
    logic [1:0] cand;
    logic       own_req;
    logic [3:0] own_data;
    logic       beat_ok;
    logic       last_beat;

    // Owner view: its request, its data slice, and whether a beat lands now.
    always_comb begin
        own_req   = req[grant_id_q];
        own_data  = req_data[{grant_id_q, 2'b00} +: 4];
        beat_ok   = (state_q == OWN) && own_req && !fifo_full;
        last_beat = (beat_cnt_q == 3'(BURST_MAX - 1));
    end

    // Round-robin search starting just above the last owner.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr_q;
        cand       = rr_ptr_q;
        for (int k = 1; k <= 4; k++) begin
            cand = rr_ptr_q + 2'(k);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state and write-side outputs.
    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        beat_cnt_d    = beat_cnt_q;
        rr_ptr_d      = rr_ptr_q;
        ack           = '0;
        fifo_write_en = 1'b0;
        fifo_data_in  = 4'h0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_id_d = pick_idx;
                    beat_cnt_d = 3'd0;
                    state_d    = OWN;
                end
            end
            OWN: begin
                fifo_data_in = own_data;
                if (beat_ok) begin
                    ack[grant_id_q] = 1'b1;
                    fifo_write_en   = 1'b1;
                    beat_cnt_d      = beat_cnt_q + 3'd1;
                end
                if ((beat_ok && last_beat) || !own_req) begin
                    rr_ptr_d = grant_id_q;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; pointer resets to 3 so requester 0 wins first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            grant_id_q <= 2'd0;
            beat_cnt_q <= 3'd0;
            rr_ptr_q   <= 2'd3;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign grant_valid = (state_q == OWN);
    assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: vector table plus
// hand-written burst, full-FIFO and mid-burst reset sequences.
module tb_fifo_write_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] req_data;
    logic [3:0]  ack;
    logic        fifo_full;
    logic        fifo_write_en;
    logic [3:0]  fifo_data_in;
    logic        grant_valid;
    logic [1:0]  grant_id;

    int n_vec = 0;
    int n_err = 0;

    fifo_write_arbiter #(
        .NREQ(4),
        .BURST_MAX(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .req_data(req_data),
        .ack(ack),
        .fifo_full(fifo_full),
        .fifo_write_en(fifo_write_en),
        .fifo_data_in(fifo_data_in),
        .grant_valid(grant_valid),
        .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] data;
        logic        full;
        logic [3:0]  ack;
        logic        we;
        logic [3:0]  din;
        logic        gv;
        logic [1:0]  gid;
    } vec_t;

    vec_t tbl[24];

    task automatic chk(string nm, logic [11:0] act, logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got {ack,we,din,gv,gid}=%h want %h",
                     nm, act, exp);
        end
    endtask

    function automatic logic [11:0] outs();
        return {ack, fifo_write_en, fifo_data_in, grant_valid, grant_id};
    endfunction

    // Invariants checked every cycle while out of reset.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            n_vec++;
            if ($countones(ack) > 1 || fifo_write_en !== (|ack) ||
                (fifo_write_en && fifo_full)) begin
                n_err++;
                $display("FAIL checker: ack=%b we=%b full=%b",
                         ack, fifo_write_en, fifo_full);
            end
        end
    end

    initial begin
        logic [3:0]  exp_q[8];
        logic [15:0] wr_mask;
        int          cnt;

        // req, data, full | ack, we, din, gv, gid
        tbl[0]  = '{4'b0000, 16'h0000, 1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, 2'd0};
        tbl[1]  = '{4'b0001, 16'h0008, 1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, 2'd0};
        tbl[2]  = '{4'b0001, 16'h0008, 1'b0, 4'b0001, 1'b1, 4'h8, 1'b1, 2'd0};
        tbl[3]  = '{4'b0001, 16'h000C, 1'b0, 4'b0001, 1'b1, 4'hC, 1'b1, 2'd0};
        tbl[4]  = '{4'b0001, 16'h0004, 1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, 2'd0};
        tbl[5]  = '{4'b0001, 16'h0004, 1'b0, 4'b0001, 1'b1, 4'h4, 1'b1, 2'd0};
        tbl[6]  = '{4'b0000, 16'h0000, 1'b0, 4'b0000, 1'b0, 4'h0, 1'b1, 2'd0};
        tbl[7]  = '{4'b0000, 16'h0000, 1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, 2'd0};
        tbl[8]  = '{4'b0100, 16'h0500, 1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, 2'd0};
        tbl[9]  = '{4'b0100, 16'h0500, 1'b1, 4'b0000, 1'b0, 4'h5, 1'b1, 2'd2};
        tbl[10] = '{4'b0100, 16'h0500, 1'b1, 4'b0000, 1'b0, 4'h5, 1'b1, 2'd2};
        tbl[11] = '{4'b0100, 16'h0500, 1'b1, 4'b0000, 1'b0, 4'h5, 1'b1, 2'd2};
        tbl[12] = '{4'b0100, 16'h0500, 1'b1, 4'b0000, 1'b0, 4'h5, 1'b1, 2'd2};
        tbl[13] = '{4'b0100, 16'h0500, 1'b1, 4'b0000, 1'b0, 4'h5, 1'b1, 2'd2};
        tbl[14] = '{4'b0100, 16'h0500, 1'b0, 4'b0100, 1'b1, 4'h5, 1'b1, 2'd2};
        tbl[15] = '{4'b0000, 16'h0000, 1'b0, 4'b0000, 1'b0, 4'h0, 1'b1, 2'd2};
        tbl[16] = '{4'b0000, 16'h0000, 1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, 2'd2};
        tbl[17] = '{4'b0010, 16'h0070, 1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, 2'd2};
        tbl[18] = '{4'b1010, 16'h9070, 1'b0, 4'b0010, 1'b1, 4'h7, 1'b1, 2'd1};
        tbl[19] = '{4'b1000, 16'h9000, 1'b0, 4'b0000, 1'b0, 4'h0, 1'b1, 2'd1};
        tbl[20] = '{4'b1000, 16'h9000, 1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, 2'd1};
        tbl[21] = '{4'b1000, 16'h9000, 1'b0, 4'b1000, 1'b1, 4'h9, 1'b1, 2'd3};
        tbl[22] = '{4'b0000, 16'h0000, 1'b0, 4'b0000, 1'b0, 4'h0, 1'b1, 2'd3};
        tbl[23] = '{4'b0000, 16'h0000, 1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, 2'd3};

        exp_q   = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3, 4'h4, 4'h4};
        wr_mask = 16'h0DB6;

        reset     = 1'b0;
        req       = 4'b0000;
        req_data  = 16'h0000;
        fifo_full = 1'b0;
        #12;
        chk("reset_state", outs(), 12'h000);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 24; i++) begin
            req       = tbl[i].req;
            req_data  = tbl[i].data;
            fifo_full = tbl[i].full;
            @(negedge clk);
            chk($sformatf("vec%0d", i), outs(),
                {tbl[i].ack, tbl[i].we, tbl[i].din, tbl[i].gv, tbl[i].gid});
            @(posedge clk);
            #1;
        end

        // All four requesting: two beats each, idle gap, then full stalls.
        cnt      = 0;
        req      = 4'b1111;
        req_data = 16'h4321;
        for (int c = 0; c < 16; c++) begin
            fifo_full = (cnt == 8);
            @(negedge clk);
            chk($sformatf("rr_we_c%0d", c),
                {11'h0, fifo_write_en}, {11'h0, wr_mask[c]});
            if (fifo_write_en) begin
                if (cnt < 8)
                    chk($sformatf("rr_data%0d", cnt),
                        {8'h0, fifo_data_in}, {8'h0, exp_q[cnt]});
                cnt++;
            end
            @(posedge clk);
            #1;
        end
        chk("rr_count", 12'(cnt), 12'd8);
        @(negedge clk);
        chk("rr_full_stall", outs(), {4'b0000, 1'b0, 4'h1, 1'b1, 2'd0});

        // Mid-burst reset while requester 3 owns the grant.
        @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        reset     = 1'b1;
        fifo_full = 1'b0;
        req       = 4'b1000;
        req_data  = 16'hA000;
        @(negedge clk);
        chk("rst_idle", outs(), {4'b0000, 1'b0, 4'h0, 1'b0, 2'd0});
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_own3", outs(), {4'b1000, 1'b1, 4'hA, 1'b1, 2'd3});
        #1;
        reset = 1'b0;
        #1;
        chk("rst_async", outs(), 12'h000);
        #2;
        reset    = 1'b1;
        req      = 4'b1111;
        req_data = 16'h4321;
        @(negedge clk);
        chk("rst_first_grant", outs(), {4'b0001, 1'b1, 4'h1, 1'b1, 2'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters; the design SHALL support exactly 4.
REQ-002 Parameter BURST_MAX, default 2: maximum beats one owner SHALL write per grant (legal range 1..8).
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  4  per-requester write request; bit i belongs to requester i.
REQ-006 req_data  input  16  per-requester data; requester i drives bits [4i+3:4i].
REQ-007 ack  output  4  one-hot beat-accepted strobe; combinational.
REQ-008 fifo_full  input  1  full flag from the shared 8-deep x 4-bit circular FIFO.
REQ-009 fifo_write_en  output  1  write enable to the FIFO; combinational.
REQ-010 fifo_data_in  output  4  write data to the FIFO; combinational.
REQ-011 grant_valid  output  1  high while an owner holds the grant (registered).
REQ-012 grant_id  output  2  index of the current owner; holds its last value when grant_valid is 0 (registered).

Function
REQ-013 Requester protocol: a requester SHALL hold req[i] high and req_data stable until ack[i] is sampled high; each ack consumes one beat; req may stay high for a following beat with new data.
REQ-014 The FSM SHALL have two states: IDLE (no owner) and OWN (owner = grant_id).
REQ-015 IDLE behaviour:
  - if req != 0 at a rising edge: select the first set bit searching upward from rr_ptr+1 (mod 4);
  - load grant_id with that index, clear beat_cnt, enter OWN.
REQ-016 No write SHALL occur in an IDLE cycle; arbitration latency SHALL be exactly 1 cycle from req rising to grant_valid.
REQ-017 In OWN:
  - fifo_write_en = ack[grant_id] = req[grant_id] AND NOT fifo_full;
  - fifo_data_in = req_data slice of grant_id.
REQ-018 All ack bits other than ack[grant_id] SHALL be 0 at all times; in IDLE, ack SHALL be 0 and fifo_write_en SHALL be 0.
REQ-019 fifo_data_in SHALL show the grant_id slice in OWN and 0 in IDLE.
REQ-020 Each accepted beat SHALL increment the 3-bit beat_cnt.
REQ-021 The owner SHALL be released (rr_ptr <= grant_id, next state IDLE) when either condition holds:
  - a beat is accepted with beat_cnt == BURST_MAX-1;
  - req[grant_id] is 0.
REQ-022 While fifo_full is high and req[grant_id] is high, the arbiter SHALL stay in OWN with no ack, no write, and beat_cnt unchanged; there is no timeout.
REQ-023 fifo_full rising in the same cycle as a pending beat SHALL block that beat; the FIFO SHALL never see fifo_write_en high while fifo_full is high.
REQ-024 Requests from non-owners SHALL be ignored until the next IDLE cycle; the minimum gap between grants SHALL be 1 IDLE cycle.
REQ-025 rr_ptr SHALL wrap 3 -> 0; with all four requesters continuously requesting, grant order SHALL be 0,1,2,3,0,... (for rr_ptr = 3 after reset).

Reset
REQ-026 Asserting reset low SHALL immediately force:
  - state = IDLE, grant_valid = 0, grant_id = 0;
  - beat_cnt = 0, rr_ptr = 3 (so requester 0 has first priority);
  - ack = 0, fifo_write_en = 0, fifo_data_in = 0.
REQ-027 Reset asserted mid-burst SHALL abort the grant with no further ack; the first grant after release SHALL follow REQ-015 from rr_ptr = 3.

Verification
REQ-028 Single requester: req=0001 with data sequence 8,12,4 -> grant_valid rises 1 cycle later; beats 8,12 written in consecutive cycles; 1 IDLE cycle; then 4 written; ack[0] pulses exactly 3 times.
REQ-029 All requesters: req=1111 held, data_i = i+1 -> FIFO receives 1,1,2,2,3,3,4,4 with an IDLE cycle between owners; fifo_full at 8 entries stalls the next beat.
REQ-030 Full stall: owner 2 is granted, fifo_full=1 for 5 cycles -> ack = 0 and fifo_write_en = 0 throughout; the beat is written in the first cycle after fifo_full falls.
REQ-031 Early release: owner 1 drops req after 1 beat -> grant released the next edge; pending requester 3 is granted after the IDLE cycle (rr_ptr = 1).
REQ-032 Reset mid-burst: reset low for 3 ns during owner 3's first beat -> outputs are 0 at once; with req=1111 after release, the first grant goes to requester 0.
REQ-033 Checker on every cycle: popcount(ack) <= 1; fifo_write_en == |ack; never (fifo_write_en AND fifo_full).
